// File: rtl/zap_mem_arbiter.sv
// ---------------------------------------------------------------------------
// zap_mem_arbiter
//
// Shares one single-ported memory slave between the core's instruction-fetch
// port and its data load/store port. Data accesses normally win; a starve
// counter forces a pending fetch through after STARVE_LIMIT consecutive data
// grants. The memory req/ack handshake is converted into the core-side
// fetch-valid pulse and the data-stall protocol.
//
// Optional feature (macro ARB_TIMEOUT_EN): abort an access that has not been
// acknowledged within TIMEOUT_CYCLES cycles. Without the macro the arbiter
// waits indefinitely for i_mem_ack.
//
// Ports
//   i_clk, i_reset_n           clock (rising edge), async active-low reset
//   i_iaddress, i_ird_en       fetch request (address held until o_ivalid)
//   o_idata, o_ivalid, o_iabort fetch completion
//   i_daddress, i_drd_en, i_dwr_en, i_dben, i_dwdata   load/store request
//   o_ddata, o_dstall, o_dabort                        data completion
//   o_mem_req, o_mem_wr, o_mem_addr, o_mem_ben, o_mem_wdata  memory request
//   i_mem_ack, i_mem_rdata, i_mem_err                        memory response
//
// FSM states
//   state | meaning
//   IDLE  | no access outstanding; grant selection happens here
//   DACC  | data access outstanding, waiting for ack
//   IACC  | fetch access outstanding, waiting for ack
// ---------------------------------------------------------------------------
module zap_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic [31:0] i_iaddress,
    input  logic        i_ird_en,
    output logic [31:0] o_idata,
    output logic        o_ivalid,
    output logic        o_iabort,

    input  logic [31:0] i_daddress,
    input  logic        i_drd_en,
    input  logic        i_dwr_en,
    input  logic [3:0]  i_dben,
    input  logic [31:0] i_dwdata,
    output logic [31:0] o_ddata,
    output logic        o_dstall,
    output logic        o_dabort,

    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_ben,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_ben_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] ireq_addr_q;
    logic [3:0]  starve_q;
    logic        d_done_q;
    logic        d_err_q;
    logic [31:0] ddata_q;
    logic        i_done_q;
    logic        i_err_q;
    logic [31:0] idata_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q;
`endif

    logic d_pend;
    logic i_starved;
    logic any_done;
    logic grant_d;
    logic grant_i;
    logic i_match;

    assign d_pend    = i_drd_en | i_dwr_en;
    assign i_starved = i_ird_en & (starve_q == STARVE_LIM);

    // In a completion cycle the core is still presenting the request that was
    // just served (it only advances after seeing the pulse), so no grant is
    // made from that cycle; otherwise the same access would be issued twice.
    assign any_done = d_done_q | i_done_q;
    assign grant_d  = (state_q == IDLE) & ~any_done & d_pend & ~i_starved;
    assign grant_i  = (state_q == IDLE) & ~any_done & ~grant_d & i_ird_en;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_ben_q   <= 4'd0;
            mem_wdata_q <= 32'd0;
            ireq_addr_q <= 32'd0;
            starve_q    <= 4'd0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            ddata_q     <= 32'd0;
            i_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            idata_q     <= 32'd0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            d_done_q <= 1'b0;
            d_err_q  <= 1'b0;
            i_done_q <= 1'b0;
            i_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    if (!i_ird_en) begin
                        starve_q <= 4'd0;
                    end

                    if (grant_d) begin
                        state_q     <= DACC;
                        mem_req_q   <= 1'b1;
                        // A simultaneous read and write request is a write.
                        mem_wr_q    <= i_dwr_en;
                        mem_addr_q  <= i_daddress & WORD_MASK;
                        mem_ben_q   <= i_dwr_en ? i_dben : 4'hF;
                        mem_wdata_q <= i_dwr_en ? i_dwdata : 32'd0;
                        if (i_ird_en && (starve_q != STARVE_LIM)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (grant_i) begin
                        state_q     <= IACC;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= i_iaddress & WORD_MASK;
                        mem_ben_q   <= 4'hF;
                        mem_wdata_q <= 32'd0;
                        ireq_addr_q <= i_iaddress;
                        starve_q    <= 4'd0;
                    end
                end

                DACC, IACC: begin
                    if (i_mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (state_q == DACC) begin
                            d_done_q <= 1'b1;
                            d_err_q  <= i_mem_err;
                            ddata_q  <= i_mem_rdata;
                        end else begin
                            i_done_q <= 1'b1;
                            i_err_q  <= i_mem_err;
                            idata_q  <= i_mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        // Slave never answered: abandon the request and
                        // complete the owning port with an abort.
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (state_q == DACC) begin
                            d_done_q <= 1'b1;
                            d_err_q  <= 1'b1;
                            ddata_q  <= 32'd0;
                        end else begin
                            i_done_q <= 1'b1;
                            i_err_q  <= 1'b1;
                            idata_q  <= 32'd0;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end

                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // A fetch result is only delivered if the PC still points at the address
    // that was fetched; after a branch it is dropped and the new PC is fetched.
    assign i_match  = (i_iaddress == ireq_addr_q);

    assign o_idata  = idata_q;
    assign o_ivalid = i_done_q & i_match;
    assign o_iabort = i_done_q & i_err_q & i_match;

    // A data completion arriving after the core withdrew its request is dropped.
    assign o_ddata  = ddata_q;
    assign o_dstall = d_pend & ~d_done_q;
    assign o_dabort = d_done_q & d_err_q & d_pend;

    assign o_mem_req   = mem_req_q;
    assign o_mem_wr    = mem_wr_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_ben   = mem_ben_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_zap_mem_arbiter.sv
module tb_zap_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_iaddress;
    logic        i_ird_en;
    logic [31:0] o_idata;
    logic        o_ivalid;
    logic        o_iabort;
    logic [31:0] i_daddress;
    logic        i_drd_en;
    logic        i_dwr_en;
    logic [3:0]  i_dben;
    logic [31:0] i_dwdata;
    logic [31:0] o_ddata;
    logic        o_dstall;
    logic        o_dabort;
    logic        o_mem_req;
    logic        o_mem_wr;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_ben;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;

    always #5 i_clk = ~i_clk;

    zap_mem_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_iaddress  (i_iaddress),
        .i_ird_en    (i_ird_en),
        .o_idata     (o_idata),
        .o_ivalid    (o_ivalid),
        .o_iabort    (o_iabort),
        .i_daddress  (i_daddress),
        .i_drd_en    (i_drd_en),
        .i_dwr_en    (i_dwr_en),
        .i_dben      (i_dben),
        .i_dwdata    (i_dwdata),
        .o_ddata     (o_ddata),
        .o_dstall    (o_dstall),
        .o_dabort    (o_dabort),
        .o_mem_req   (o_mem_req),
        .o_mem_wr    (o_mem_wr),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ben   (o_mem_ben),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_err   (i_mem_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  ben;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        abt;
        bit          chk;
    } cpl_t;

    req_t exp_req[$];
    cpl_t exp_d[$];
    cpl_t exp_i[$];

    int n_checks = 0;
    int n_errs   = 0;
    bit slave_hang = 1'b0;
    bit slave_err  = 1'b0;
    int slave_wait = 0;
    int wcnt       = 0;
    bit req_seen   = 1'b0;
    int d_cpl_cnt  = 0;
    int i_at_cnt   = 0;

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Monitor + slave model, evaluated on the falling edge.
    initial begin : mon
        req_t r;
        cpl_t c;
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                if (o_mem_req && !req_seen) begin
                    req_seen = 1'b1;
                    if (exp_req.size() == 0) begin
                        check("unexp_req", 32'(o_mem_req), 32'd0);
                    end else begin
                        r = exp_req.pop_front();
                        check("req_addr", o_mem_addr, r.addr);
                        check("req_wr", 32'(o_mem_wr), 32'(r.wr));
                        check("req_ben", 32'(o_mem_ben), 32'(r.ben));
                        if (r.wr) check("req_wdata", o_mem_wdata, r.wdata);
                    end
                end
                if (o_ivalid) begin
                    i_at_cnt = d_cpl_cnt;
                    if (exp_i.size() == 0) begin
                        check("unexp_ivalid", 32'(o_ivalid), 32'd0);
                    end else begin
                        c = exp_i.pop_front();
                        if (c.chk) check("idata", o_idata, c.data);
                        check("iabort", 32'(o_iabort), 32'(c.abt));
                    end
                end
                if ((i_drd_en | i_dwr_en) && !o_dstall) begin
                    d_cpl_cnt++;
                    if (exp_d.size() == 0) begin
                        check("unexp_dcpl", 32'(o_dstall), 32'd1);
                    end else begin
                        c = exp_d.pop_front();
                        if (c.chk) check("ddata", o_ddata, c.data);
                        check("dabort", 32'(o_dabort), 32'(c.abt));
                    end
                end
            end
            if (!o_mem_req) req_seen = 1'b0;

            i_mem_ack = 1'b0;
            i_mem_err = 1'b0;
            if (o_mem_req && !slave_hang) begin
                if (wcnt >= slave_wait) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mdl(o_mem_addr);
                    i_mem_err   = slave_err;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic wait_req();
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge i_clk);
            if (o_mem_req) ok = 1'b1;
        end
        if (!ok) check("req_timeout", 32'(o_mem_req), 32'd1);
    endtask

    task automatic wait_ivalid();
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge i_clk);
            if (o_ivalid) ok = 1'b1;
        end
        if (!ok) check("ivalid_timeout", 32'(o_ivalid), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        i_iaddress = a;
        i_ird_en   = 1'b1;
        wait_ivalid();
        @(posedge i_clk); #1;
        i_ird_en = 1'b0;
    endtask

    task automatic data_op(input logic [31:0] a, input bit rd, input bit wr,
                           input logic [3:0] ben, input logic [31:0] wd, input bit keep);
        bit ok = 1'b0;
        i_daddress = a;
        i_drd_en   = rd;
        i_dwr_en   = wr;
        i_dben     = ben;
        i_dwdata   = wd;
        #1 check("dstall_hold", 32'(o_dstall), 32'd1);
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge i_clk);
            if (!o_dstall) ok = 1'b1;
        end
        if (!ok) check("d_timeout", 32'(o_dstall), 32'd0);
        @(posedge i_clk); #1;
        if (!keep) begin
            i_drd_en = 1'b0;
            i_dwr_en = 1'b0;
        end
    endtask

    initial begin : main
        int base;
        int cyc;
        i_reset_n   = 1'b0;
        i_iaddress  = 32'd0;
        i_ird_en    = 1'b0;
        i_daddress  = 32'd0;
        i_drd_en    = 1'b0;
        i_dwr_en    = 1'b0;
        i_dben      = 4'd0;
        i_dwdata    = 32'd0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'd0;
        i_mem_err   = 1'b0;

        #1;
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_ben", 32'(o_mem_ben), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_ivalid", 32'(o_ivalid), 32'd0);
        check("rst_dabort", 32'(o_dabort), 32'd0);
        check("rst_dstall", 32'(o_dstall), 32'd0);
        check("rst_ddata", o_ddata, 32'd0);

        repeat (2) @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        repeat (4) @(posedge i_clk);
        #1;

        // Fetch only, slave acks two cycles after request
        slave_wait = 2;
        exp_req.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
        exp_i.push_back('{mdl(32'h100), 1'b0, 1'b1});
        do_fetch(32'h100);

        // Unaligned byte store
        slave_wait = 0;
        exp_req.push_back('{32'h1F0, 1'b1, 4'b0100, 32'h00AB_0000});
        exp_d.push_back('{32'h0, 1'b0, 1'b0});
        data_op(32'h1F3, 1'b0, 1'b1, 4'b0100, 32'h00AB_0000, 1'b0);

        // Read and write together behaves as a write
        exp_req.push_back('{32'h700, 1'b1, 4'h3, 32'h1234_5678});
        exp_d.push_back('{32'h0, 1'b0, 1'b0});
        data_op(32'h701, 1'b1, 1'b1, 4'h3, 32'h1234_5678, 1'b0);

        // Continuous loads with a pending fetch: D,D,D,D,I,D
        for (int k = 0; k < 4; k++) begin
            exp_req.push_back('{32'h400 + 32'(4 * k), 1'b0, 4'hF, 32'h0});
            exp_d.push_back('{mdl(32'h400 + 32'(4 * k)), 1'b0, 1'b1});
        end
        exp_req.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
        exp_req.push_back('{32'h410, 1'b0, 4'hF, 32'h0});
        exp_d.push_back('{mdl(32'h410), 1'b0, 1'b1});
        exp_i.push_back('{mdl(32'h300), 1'b0, 1'b1});
        base = d_cpl_cnt;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    data_op(32'h400 + 32'(4 * k), 1'b1, 1'b0, 4'h0, 32'h0, k < 4);
            end
            do_fetch(32'h300);
        join
        check("starve_dcnt", 32'(i_at_cnt - base), 32'd4);

        // Branch while a fetch is in flight
        slave_wait = 2;
        exp_req.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
        exp_req.push_back('{32'h200, 1'b0, 4'hF, 32'h0});
        exp_i.push_back('{mdl(32'h200), 1'b0, 1'b1});
        i_iaddress = 32'h100;
        i_ird_en   = 1'b1;
        wait_req();
        @(posedge i_clk); #1;
        i_iaddress = 32'h200;
        wait_ivalid();
        @(posedge i_clk); #1;
        i_ird_en = 1'b0;

        // Load with bus error, then a clean load
        slave_wait = 1;
        slave_err  = 1'b1;
        exp_req.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
        exp_d.push_back('{mdl(32'h500), 1'b1, 1'b1});
        data_op(32'h502, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        slave_err = 1'b0;
        exp_req.push_back('{32'h504, 1'b0, 4'hF, 32'h0});
        exp_d.push_back('{mdl(32'h504), 1'b0, 1'b1});
        data_op(32'h504, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of a data access
        slave_hang = 1'b1;
        exp_req.push_back('{32'h600, 1'b0, 4'hF, 32'h0});
        i_daddress = 32'h600;
        i_drd_en   = 1'b1;
        wait_req();
        #2 i_reset_n = 1'b0;
        #1 check("rst_mid_req", 32'(o_mem_req), 32'd0);
        i_drd_en = 1'b0;
        @(posedge i_clk); #3;
        i_reset_n  = 1'b1;
        slave_hang = 1'b0;
        @(posedge i_clk); #1;
        exp_req.push_back('{32'h604, 1'b0, 4'hF, 32'h0});
        exp_d.push_back('{mdl(32'h604), 1'b0, 1'b1});
        data_op(32'h604, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: access aborts after TIMEOUT_CYCLES
        slave_hang = 1'b1;
        exp_req.push_back('{32'h800, 1'b0, 4'hF, 32'h0});
        exp_d.push_back('{32'h0, 1'b1, 1'b1});
        i_daddress = 32'h800;
        i_drd_en   = 1'b1;
        wait_req();
        cyc = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (!o_mem_req) break;
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd8);
        check("to_dstall", 32'(o_dstall), 32'd0);
        @(posedge i_clk); #1;
        i_drd_en   = 1'b0;
        slave_hang = 1'b0;
`else
        cyc = 0;
`endif

        repeat (4) @(posedge i_clk);
        #1;
        check("left_req", 32'(exp_req.size()), 32'd0);
        check("left_d", 32'(exp_d.size()), 32'd0);
        check("left_i", 32'(exp_i.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
